machine_timer_unit: RTL and testbench
=====================================

// Module: machine_timer_unit
// PURPOSE
//  Memory-mapped machine timer/software-interrupt unit. Holds 64-bit mtime and mtimecmp plus msip.
//  Drives the mtip/msip bits consumed by the mip register in the privileged CSR block.
//  Exports mtime for the user time/timeh CSRs. Sits on the core's peripheral bus, upstream of the CSR file.
// PARAMETERS
//  PRESCALE      16  CLK cycles per mtime increment; legal range 1..65535. 1 means increment every cycle.
//  MTIMECMP_RST  64'hFFFF_FFFF_FFFF_FFFF  reset value of mtimecmp (no interrupt out of reset)
// PORTS
//  CLK        in   1   clock
//  RST        in   1   asynchronous reset, active-high
//  req        in   1   bus request; held until ack
//  wen        in   1   1=write, 0=read (valid with req)
//  addr       in   5   byte offset; 0x00 mtime, 0x04 mtimeh, 0x08 mtimecmp, 0x0C mtimecmph, 0x10 msip
//  wdata      in   32  write data
//  ack        out  1   one-cycle pulse completing the request
//  err        out  1   with ack: unmapped or unaligned addr
//  rdata      out  32  read data, valid while ack=1
//  mtime_out  out  64  current mtime (feeds time/timeh CSRs)
//  mtip       out  1   machine timer interrupt pending
//  msip       out  1   machine software interrupt pending
// BEHAVIOUR
//  Reset values:
//   - mtime=0, mtimecmp=MTIMECMP_RST, msip=0, prescaler count=0
//   - ack=0, err=0, rdata=0, mtip=0
//  Bus FSM (IDLE, RESP):
//   - IDLE: req=1 -> RESP; the access is performed on this edge.
//   - RESP: ack=1 for exactly one cycle -> IDLE. A new request is not accepted in RESP.
//   - Latency is 1 cycle from req to ack. req held high gives back-to-back accesses every 2 cycles.
//  Address decode:
//   - addr[1:0]!=0 or unmapped offset: ack=1, err=1, rdata=0, no state change.
//   - msip read returns {31'b0,msip}; a write sets msip<=wdata[0], other bits ignored.
//  Prescaler:
//   - Counter 0..PRESCALE-1. mtime increments by 1 (wraps 2^64-1 -> 0) on the cycle the counter is at PRESCALE-1.
//  Writes to mtime or mtimeh:
//   - The written half takes wdata. The other half holds.
//   - No increment occurs that cycle, including any carry from the low half.
//   - The prescaler resets to 0.
//  Writes to mtimecmp or mtimecmph:
//   - Replace that half only.
//  mtip:
//   - Registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit, evaluated on post-update values.
//   - Appears 1 cycle after the condition becomes true.
//   - Clears 1 cycle after a mtimecmp write that makes the condition false.
//  msip:
//   - Driven directly from its register.
//  Simultaneous events:
//   - A bus write wins over the increment. Reads return pre-edge values.
//  Reset mid-transaction:
//   - Aborts it. ack is not issued. FSM returns to IDLE.
// CONFIGURATION
//  MTIME_ATOMIC_READ_EN defined:
//   - A read of mtime (0x00) also snapshots mtime[63:32] into a shadow register.
//   - The next mtimeh (0x04) read returns the shadow, then invalidates it.
//   - Any mtime/mtimeh write invalidates the shadow.
//   - An mtimeh read with no valid shadow returns live mtime[63:32].
//  Not defined:
//   - No shadow register. mtimeh always reads live.
// STRUCTURE
//  Shared package (machine_mode_types_1_11_pkg):
//   - timer_offset_t enum for offsets 0x00/0x04/0x08/0x0C/0x10
//   - MTIMECMP_RST default constant
//   - reuse mtime_t/mtimeh_t/mtimecmp_t
//   - bus_state_t {IDLE, RESP}
//  Sub-module timer_prescaler:
//   - Parameter PRESCALE; inputs CLK, RST, clear; output tick.
//  Everything else lives in this module.
// TESTING
//  1. Reset, PRESCALE=4, idle 40 cycles -> mtime_out=10, mtip=0, msip=0.
//  2. Write mtimecmp=0x20, mtimecmph=0, then wait until mtime=0x20 -> mtip rises 1 cycle after.
//     Write mtimecmp=0x100 -> mtip=0 one cycle later.
//  3. Write mtime=0xFFFF_FFFF on the same edge the prescaler ticks -> mtime=0x0000_0000_FFFF_FFFF, no carry.
//     Next tick -> mtime=0x1_0000_0000.
//  4. Write msip wdata=0xFFFF_FFFF -> msip=1, read 0x10 returns 0x1. Write 0 -> msip=0.
//  5. Read addr 0x02 and addr 0x14 -> ack=1, err=1, rdata=0, no state change.
//     Check each ack is exactly 1 cycle after req.
//  6. With MTIME_ATOMIC_READ_EN, mtime=0xFFFF_FFFE, PRESCALE=1:
//     - read 0x00 then 0x04 -> 0xFFFF_FFFE, 0x0000_0000 (no tear)
//     - without the macro -> the 0x04 read returns 0x1

Source files
------------

// File: rtl/machine_mode_types_1_11_pkg.sv
// Shared types and constants for the machine timer unit: bus offsets, register
// types, bus FSM states and the address decode helper.
package machine_mode_types_1_11_pkg;

  typedef logic [63:0] mtime_t;
  typedef logic [31:0] mtimeh_t;
  typedef logic [63:0] mtimecmp_t;
  typedef logic [15:0] presc_cnt_t;

  localparam mtimecmp_t MTIMECMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [4:0] {
    OFF_MTIME     = 5'h00,
    OFF_MTIMEH    = 5'h04,
    OFF_MTIMECMP  = 5'h08,
    OFF_MTIMECMPH = 5'h0C,
    OFF_MSIP      = 5'h10
  } timer_offset_t;

  typedef logic [0:0] bus_state_t;
  localparam bus_state_t IDLE = 1'b0;
  localparam bus_state_t RESP = 1'b1;

  // Only the five word-aligned offsets are mapped, so misaligned addresses fall out here too.
  function automatic logic addr_mapped(input logic [4:0] a);
    logic hit;
    case (a)
      OFF_MTIME, OFF_MTIMEH, OFF_MTIMECMP, OFF_MTIMECMPH, OFF_MSIP: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/machine_timer_unit_prescaler.sv
// Free-running divider: tick is high during the cycle the count sits at PRESCALE-1.
// clear restarts the count from 0 on the next edge.
module timer_prescaler
  import machine_mode_types_1_11_pkg::*;
#(
  parameter int unsigned PRESCALE = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam presc_cnt_t LAST = presc_cnt_t'(PRESCALE - 32'd1);

  presc_cnt_t count;

  assign tick = (count == LAST);

  // Counter wraps on tick; with PRESCALE=1 it stays at 0 and ticks every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= 16'd0;
    end else if (clear || tick) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/machine_timer_unit.sv
// Memory-mapped mtime/mtimecmp/msip unit with a one-cycle-latency bus handshake.
// Optional macro MTIME_ATOMIC_READ_EN adds a shadow of mtime[63:32] captured on mtime reads.
module machine_timer_unit
  import machine_mode_types_1_11_pkg::*;
#(
  parameter int unsigned PRESCALE     = 16,
  parameter logic [63:0] MTIMECMP_RST = MTIMECMP_RST_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        wen,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [63:0] mtime_out,
  output logic        mtip,
  output logic        msip
);

  bus_state_t state;
  mtime_t     mtime;
  mtimecmp_t  mtimecmp;
  logic       tick;
  logic       accept;
  logic       mapped;
  logic       wr_mtime_lo;
  logic       wr_mtime_hi;
  logic       wr_cmp_lo;
  logic       wr_cmp_hi;
  logic       wr_msip;
  logic       timer_write;
  logic [31:0] rd_val;

`ifdef MTIME_ATOMIC_READ_EN
  mtimeh_t shadow_hi;
  logic    shadow_valid;
`endif

  assign accept      = (state == IDLE) && req;
  assign mapped      = addr_mapped(addr);
  assign wr_mtime_lo = accept && wen && (addr == OFF_MTIME);
  assign wr_mtime_hi = accept && wen && (addr == OFF_MTIMEH);
  assign wr_cmp_lo   = accept && wen && (addr == OFF_MTIMECMP);
  assign wr_cmp_hi   = accept && wen && (addr == OFF_MTIMECMPH);
  assign wr_msip     = accept && wen && (addr == OFF_MSIP);
  assign timer_write = wr_mtime_lo || wr_mtime_hi;
  assign mtime_out   = mtime;

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK   (CLK),
    .RST   (RST),
    .clear (timer_write),
    .tick  (tick)
  );

  // Read mux over pre-edge register values.
  always_comb begin
    rd_val = 32'd0;
    case (addr)
      OFF_MTIME:     rd_val = mtime[31:0];
`ifdef MTIME_ATOMIC_READ_EN
      OFF_MTIMEH:    rd_val = shadow_valid ? shadow_hi : mtime[63:32];
`else
      OFF_MTIMEH:    rd_val = mtime[63:32];
`endif
      OFF_MTIMECMP:  rd_val = mtimecmp[31:0];
      OFF_MTIMECMPH: rd_val = mtimecmp[63:32];
      OFF_MSIP:      rd_val = {31'd0, msip};
      default:       rd_val = 32'd0;
    endcase
  end

  // Bus handshake: accept in IDLE, pulse ack for one cycle in RESP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RESP;
            ack   <= 1'b1;
            err   <= ~mapped;
            rdata <= (wen || !mapped) ? 32'd0 : rd_val;
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'd0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'd0;
        end
      endcase
    end
  end

  // A bus write to either half suppresses that cycle's increment entirely, carry included.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mtime <= 64'd0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= wdata;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Compare register and software interrupt bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= wdata;
      if (wr_msip)   msip            <= wdata[0];
    end
  end

  // Timer interrupt compares the settled register values, so it lags its cause by one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mtip <= 1'b0;
    end else begin
      mtip <= (mtime >= mtimecmp);
    end
  end

`ifdef MTIME_ATOMIC_READ_EN
  // Shadow of the upper half, armed by an mtime read and consumed by the next mtimeh read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_hi    <= 32'd0;
      shadow_valid <= 1'b0;
    end else if (accept && !wen && (addr == OFF_MTIME)) begin
      shadow_hi    <= mtime[63:32];
      shadow_valid <= 1'b1;
    end else if ((accept && !wen && (addr == OFF_MTIMEH)) || timer_write) begin
      shadow_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_machine_timer_unit.sv
// Directed bench for machine_timer_unit: one DUT with PRESCALE=4 for the timer tests,
// a second with PRESCALE=1 for the mtime/mtimeh read-tear scenario.
`timescale 1ns/1ps
module tb_machine_timer_unit;

  logic        CLK;
  logic        RST;
  logic        req, wen, ack, err, mtip, msip;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic [63:0] mtime_out;
  logic        req2, wen2, ack2, err2, mtip2, msip2;
  logic [4:0]  addr2;
  logic [31:0] wdata2, rdata2;
  logic [63:0] mtime_out2;

  int checks = 0;
  int errors = 0;

  machine_timer_unit #(.PRESCALE(4)) dut (
    .CLK(CLK), .RST(RST), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .mtime_out(mtime_out), .mtip(mtip), .msip(msip)
  );

  machine_timer_unit #(.PRESCALE(1)) dut2 (
    .CLK(CLK), .RST(RST), .req(req2), .wen(wen2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .err(err2), .rdata(rdata2), .mtime_out(mtime_out2), .mtip(mtip2), .msip(msip2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One bus access on the selected DUT; lat counts edges from request to ack (bounded).
  task automatic bus(input bit sel, input logic w, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    @(posedge CLK); #1;
    if (sel) begin req2 = 1'b1; wen2 = w; addr2 = a; wdata2 = d; end
    else     begin req  = 1'b1; wen  = w; addr  = a; wdata  = d; end
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!(sel ? ack2 : ack) && lat < 8);
    rd = sel ? rdata2 : rdata;
    e  = sel ? err2 : err;
    if (sel) req2 = 1'b0; else req = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req = 1'b0; wen = 1'b0; addr = 5'd0; wdata = 32'd0;
    req2 = 1'b0; wen2 = 1'b0; addr2 = 5'd0; wdata2 = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (mtime_out !== 64'd0) begin errors++; $display("FAIL reset_mtime: got %h expected 0", mtime_out); end
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL reset_mtip: got %b expected 0", mtip); end
    checks++; if (msip !== 1'b0) begin errors++; $display("FAIL reset_msip: got %b expected 0", msip); end
    RST = 1'b0;
  endtask

  task automatic test_prescale();
    logic [31:0] rd; logic e; int lat;
    repeat (40) @(posedge CLK);
    #1;
    checks++; if (mtime_out !== 64'd10) begin errors++; $display("FAIL prescale_mtime: got %h expected a", mtime_out); end
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL prescale_mtip: got %b expected 0", mtip); end
    checks++; if (msip !== 1'b0) begin errors++; $display("FAIL prescale_msip: got %b expected 0", msip); end
    bus(1'b0, 1'b0, 5'h08, 32'd0, rd, e, lat);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_reset_read: got %h expected ffffffff", rd); end
    checks++; if (lat != 1) begin errors++; $display("FAIL cmp_reset_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_mtip();
    logic [31:0] rd; logic e; int lat; int n;
    bus(1'b0, 1'b1, 5'h08, 32'h20, rd, e, lat);
    bus(1'b0, 1'b1, 5'h0C, 32'h0, rd, e, lat);
    n = 0;
    while (mtime_out !== 64'h20 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++; if (mtime_out !== 64'h20) begin errors++; $display("FAIL mtip_wait: got %h expected 20 (timeout)", mtime_out); end
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL mtip_not_early: got %b expected 0", mtip); end
    @(posedge CLK); #1;
    checks++; if (mtip !== 1'b1) begin errors++; $display("FAIL mtip_rise: got %b expected 1", mtip); end
    bus(1'b0, 1'b1, 5'h08, 32'h100, rd, e, lat);
    checks++; if (mtip !== 1'b1) begin errors++; $display("FAIL mtip_hold_on_write: got %b expected 1", mtip); end
    @(posedge CLK); #1;
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL mtip_clear: got %b expected 0", mtip); end
  endtask

  task automatic test_no_carry();
    logic [31:0] rd; logic e; int lat;
    bus(1'b0, 1'b1, 5'h04, 32'h0, rd, e, lat);
    repeat (2) @(posedge CLK);
    // Lands on the fourth edge after the prescaler was cleared, i.e. a tick edge.
    bus(1'b0, 1'b1, 5'h00, 32'hFFFF_FFFF, rd, e, lat);
    checks++; if (mtime_out !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL no_carry: got %h expected 00000000ffffffff", mtime_out); end
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (mtime_out !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL no_early_tick: got %h expected 00000000ffffffff", mtime_out); end
    @(posedge CLK); #1;
    checks++; if (mtime_out !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL carry_tick: got %h expected 0000000100000000", mtime_out); end
  endtask

  task automatic test_msip();
    logic [31:0] rd; logic e; int lat;
    bus(1'b0, 1'b1, 5'h10, 32'hFFFF_FFFF, rd, e, lat);
    checks++; if (msip !== 1'b1) begin errors++; $display("FAIL msip_set: got %b expected 1", msip); end
    bus(1'b0, 1'b0, 5'h10, 32'd0, rd, e, lat);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL msip_read: got %h expected 1", rd); end
    bus(1'b0, 1'b1, 5'h10, 32'h0, rd, e, lat);
    checks++; if (msip !== 1'b0) begin errors++; $display("FAIL msip_clear: got %b expected 0", msip); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    bus(1'b0, 1'b0, 5'h02, 32'd0, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_unaligned: got %b expected 1", e); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL err_unaligned_rdata: got %h expected 0", rd); end
    checks++; if (lat != 1) begin errors++; $display("FAIL err_unaligned_latency: got %0d expected 1", lat); end
    bus(1'b0, 1'b0, 5'h14, 32'd0, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_unmapped: got %b expected 1", e); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL err_unmapped_rdata: got %h expected 0", rd); end
    checks++; if (lat != 1) begin errors++; $display("FAIL err_unmapped_latency: got %0d expected 1", lat); end
    bus(1'b0, 1'b1, 5'h0A, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_write_unaligned: got %b expected 1", e); end
    bus(1'b0, 1'b1, 5'h11, 32'h1, rd, e, lat);
    checks++; if (msip !== 1'b0) begin errors++; $display("FAIL err_msip_untouched: got %b expected 0", msip); end
    bus(1'b0, 1'b0, 5'h08, 32'd0, rd, e, lat);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL err_cmp_untouched: got %h expected 100", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ok_read_err: got %b expected 0", e); end
  endtask

  task automatic test_atomic_read();
    logic [31:0] rd; logic e; int lat;
    logic [31:0] exp_hi;
`ifdef MTIME_ATOMIC_READ_EN
    exp_hi = 32'h0;
`else
    exp_hi = 32'h1;
`endif
    bus(1'b1, 1'b1, 5'h04, 32'h0, rd, e, lat);
    bus(1'b1, 1'b1, 5'h00, 32'hFFFF_FFFD, rd, e, lat);
    bus(1'b1, 1'b0, 5'h00, 32'd0, rd, e, lat);
    checks++; if (rd !== 32'hFFFF_FFFE) begin errors++; $display("FAIL atomic_lo: got %h expected fffffffe", rd); end
    bus(1'b1, 1'b0, 5'h04, 32'd0, rd, e, lat);
    checks++; if (rd !== exp_hi) begin errors++; $display("FAIL atomic_hi: got %h expected %h", rd, exp_hi); end
    bus(1'b1, 1'b0, 5'h04, 32'd0, rd, e, lat);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL atomic_hi_live: got %h expected 1", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat;
    @(posedge CLK); #1;
    req = 1'b1; wen = 1'b0; addr = 5'h00;
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", ack); end
    checks++; if (mtime_out !== 64'd0) begin errors++; $display("FAIL abort_mtime: got %h expected 0", mtime_out); end
    req = 1'b0;
    @(posedge CLK); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack_late: got %b expected 0", ack); end
    RST = 1'b0;
    bus(1'b0, 1'b0, 5'h08, 32'd0, rd, e, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL abort_idle_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL abort_cmp_reset: got %h expected ffffffff", rd); end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_mtip();
    test_no_carry();
    test_msip();
    test_errors();
    test_atomic_read();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
